// File: rtl/afifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks (wptr_full, rptr_empty).
// Contents:
//   GRAY_W    - widest pointer the conversion functions handle
//   bin2gray  - binary to reflected Gray code
//   gray2bin  - reflected Gray code to binary
// Both functions work on zero-extended GRAY_W-bit values. Leading zeros do not
// change either conversion, so a caller of any pointer width extends its value,
// calls the function and truncates the result back to its own width.
package afifo_pkg;

  localparam int GRAY_W = 32;

  // Binary to Gray: each bit is XORed with its upper neighbour.
  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b = g;
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side bundle between the write-domain producer and wptr_full.
// Parameter:
//   size         - FIFO address width (pointers are size+1 bits)
// Signals:
//   winc         - write request from the producer
//   wq2_rptr     - read Gray pointer already synchronized into the write clock
//   waddr        - RAM write address
//   wptr         - Gray write pointer towards the read-domain synchronizer
//   wfull        - FIFO full
//   walmost_full - occupancy at or above the almost-full threshold
//   wlevel       - conservative occupancy
//   woverflow    - sticky flag: a write was attempted while full
// Modports: master = producer side, slave = wptr_full.
interface wptr_full_if #(
  parameter int size = 4
);

  logic            winc;
  logic [size:0]   wq2_rptr;
  logic [size-1:0] waddr;
  logic [size:0]   wptr;
  logic            wfull;
  logic            walmost_full;
  logic [size:0]   wlevel;
  logic            woverflow;

  modport master (
    output winc,
    output wq2_rptr,
    input  waddr,
    input  wptr,
    input  wfull,
    input  walmost_full,
    input  wlevel,
    input  woverflow
  );

  modport slave (
    input  winc,
    input  wq2_rptr,
    output waddr,
    output wptr,
    output wfull,
    output walmost_full,
    output wlevel,
    output woverflow
  );

endinterface

// File: rtl/wptr_full.sv
// Write-side pointer and status generator of the asynchronous FIFO.
// Runs entirely in the write clock domain. It counts accepted writes, provides
// the RAM write address and the Gray write pointer that is carried into the
// read domain, and derives full / almost-full / level / overflow from the read
// pointer already synchronized into this domain.
// Parameters:
//   size      - FIFO address width, depth = 2**size, >= 2
//   AF_THRESH - almost-full threshold in entries, 1..2**size
// Ports:
//   clk       - write-domain clock
//   rst_n     - asynchronous active-low reset, clears every register
//   bus       - wptr_full_if slave modport (winc, wq2_rptr in; status out)
module wptr_full
  import afifo_pkg::*;
#(
  parameter int size      = 4,
  parameter int AF_THRESH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  wptr_full_if.slave  bus
);

  localparam int          PW    = size + 1;
  localparam logic [31:0] AF_U  = 32'(AF_THRESH);

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wbin_d;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] wptr_d;
  logic [PW-1:0] wlevel_q;
  logic [PW-1:0] wlevel_d;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_cmp_s;
  logic          wen_s;
  logic          wfull_q;
  logic          wfull_d;
  logic          walmost_full_q;
  logic          walmost_full_d;
  logic          woverflow_q;
  logic          woverflow_d;

  // Next-state computation for pointers and status flags.
  always_comb begin
    wen_s      = bus.winc & ~wfull_q;
    wbin_d     = wbin_q + {{size{1'b0}}, wen_s};
    wptr_d     = PW'(bin2gray(32'(wbin_d)));
    rbin_s     = PW'(gray2bin(32'(bus.wq2_rptr)));
    // Full when the write pointer has lapped the read pointer exactly once:
    // the two Gray MSBs differ and all remaining bits match.
    full_cmp_s = {~bus.wq2_rptr[size:size-1], bus.wq2_rptr[size-2:0]};
    wfull_d    = (wptr_d == full_cmp_s);
    // Modular difference; the read pointer never passes the write pointer,
    // so the result stays within 0..2**size.
    wlevel_d       = wbin_d - rbin_s;
    walmost_full_d = ({{(32-PW){1'b0}}, wlevel_d} >= AF_U);
    woverflow_d    = woverflow_q | (bus.winc & wfull_q);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q         <= {PW{1'b0}};
      wptr_q         <= {PW{1'b0}};
      wlevel_q       <= {PW{1'b0}};
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  // The RAM address is the registered binary pointer, so it holds the
  // pre-increment value on the edge that accepts a write.
  assign bus.waddr        = wbin_q[size-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = woverflow_q;

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and status generator for the asynchronous FIFO. Runs entirely in the write clock domain: counts accepted writes, produces the RAM write address and the Gray-coded write pointer that the `sync` block carries into the read domain. It also consumes the read pointer already synchronized into this domain and derives full, almost-full, level and overflow status.

## Interface
- `size`, 4: FIFO address width; depth = 2**size; pointers are size+1 bits; legal range ≥ 2
- `AF_THRESH`, 12: almost-full threshold in entries; legal range 1..2**size
- `clk`  in  1  write-domain clock
- `rst_n`  in  1  asynchronous active-low reset
- `winc`  in  1  write request, sampled on posedge clk
- `wq2_rptr`  in  size+1  read Gray pointer, already two-flop synchronized into clk domain
- `waddr`  out  size  RAM write address
- `wptr`  out  size+1  registered Gray write pointer, sent to the read-domain synchronizer
- `wfull`  out  1  FIFO full
- `walmost_full`  out  1  level ≥ AF_THRESH
- `wlevel`  out  size+1  conservative occupancy, 0..2**size
- `woverflow`  out  1  sticky: write attempted while full

## Operation
- State: binary pointer `wbin` (size+1), Gray pointer `wptr`, `wfull`, `walmost_full`, `wlevel`, `woverflow`; all registered.
- Reset (async, rst_n low): every register and output is 0. Reset may assert at any cycle; a write in flight at reset is discarded.
- Write accept: `wen = winc & ~wfull`. `wbin_next = wbin + wen`, wrapping modulo 2**(size+1).
- `wgray_next = (wbin_next >> 1) ^ wbin_next`; `wptr <= wgray_next`.
- `waddr = wbin[size-1:0]`, a direct register output with no combinational path from `winc`.
- Full: `wfull <= (wgray_next == {~wq2_rptr[size:size-1], wq2_rptr[size-2:0]})`.
- Level: `rbin = gray2bin(wq2_rptr)`; `wlevel <= wbin_next - rbin` (size+1-bit modular subtraction; result never exceeds 2**size).
- `walmost_full <= (level_next >= AF_THRESH)`, where level_next is the value being loaded into `wlevel`.
- Overflow: `woverflow <= woverflow | (winc & wfull)`. The refused write does not change `wbin`, `wptr` or `waddr`. Only reset clears `woverflow`.
- Boundary conditions:
  - Pointer wrap at 2**(size+1) is handled by modular arithmetic.
  - The MSB pair comparison distinguishes full from empty.
  - When a write and a `wq2_rptr` advance land on the same edge, both are reflected in the next-cycle flags.

## Timing
- Write accepted at edge N:
  - `waddr` and `wptr` advance after edge N.
  - The RAM writes at `waddr` on edge N, using the pre-increment value.
- `wfull` asserts after the same edge N that accepts the filling write. No write is ever accepted while full.
- Flag clearing is pessimistic by design:
  - `wfull` deasserts and `walmost_full`/`wlevel` drop one clk edge after `wq2_rptr` changes.
  - End to end, that is 3 wclk edges after the read-domain pointer update, including the 2-flop sync.
- `wptr` changes at most one Gray bit per clk, which is what makes it safe for the synchronizer.

## Structure
- Shared package `afifo_pkg`: functions `bin2gray` and `gray2bin`, parameterized by width. The read-side `rptr_empty` block reuses the same package.
- One natural sub-module: none is needed. The Gray conversions are package functions. Implement as a single module, roughly 120–160 lines.

## Test plan
All scenarios use size=4, AF_THRESH=12.
- **Reset:** hold rst_n=0 for 3 clks, then release → `waddr=0`, `wptr=0`, `wfull=0`, `walmost_full=0`, `wlevel=0`, `woverflow=0`.
- **Fill:** wq2_rptr=0, 16 consecutive winc.
  - After the 12th write: `walmost_full=1`, `wlevel=12`.
  - After the 16th write: `wfull=1`, `wlevel=16`, `wptr=5'b11000`, `waddr=0`.
- **Overflow:** while full, 2 more winc → `wptr` stays 5'b11000, `woverflow=1`. `woverflow` stays 1 after wq2_rptr later advances.
- **Drain release:** from full, set wq2_rptr = Gray(4) = 5'b00110 → next edge `wfull=0`, `wlevel=12`, `walmost_full=1`. Then set wq2_rptr = Gray(5) → `wlevel=11`, `walmost_full=0`.
- **Wrap:** 40 writes with wq2_rptr tracking writes at a 2-cycle lag.
  - `wptr` passes through Gray(31)=5'b10000 to Gray(0)=5'b00000.
  - Hamming distance between successive `wptr` values is ≤1.
  - `wfull` is never set.
- **Reset mid-operation:** after 7 writes, pulse rst_n low asynchronously, between clock edges → all outputs are 0 immediately. The next write yields `waddr=1` and `wptr=5'b00001`.
